stream_width_packer: RTL and testbench
======================================

# stream_width_packer

Parametrised successor to the fixed 8-to-24 data width converter. Packs RATIO consecutive IN_W-bit beats from the byte-serial receive stream into one IN_W*RATIO-bit pixel word, using valid/ready handshakes on both sides. Counts output pixels per frame, flags the last pixel of each frame, and supports selectable beat order. It sits between the serial receiver and the line-buffer write path / control FSM.

## Interface
- IN_W, 8: input beat width in bits (≥1).
- RATIO, 3: input beats per output word (≥1).
- MSB_FIRST, 1: 1 = first beat lands in the top IN_W bits; 0 = first beat lands in bits [IN_W-1:0].
- FRAME_PIXELS, 4096: output words per frame (≥1), e.g. WIDTH*HEIGHT.
- OUT_W (derived, not overridable): IN_W*RATIO.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  IN_W  input beat.
- valid_in  in  1  input beat valid.
- ready_in  out  1  block can accept a beat.
- flush  in  1  synchronous; discards a partially collected word.
- data_out  out  OUT_W  packed word.
- valid_out  out  1  data_out valid.
- ready_out  in  1  downstream accepts the word.
- last_out  out  1  data_out is the frame's final pixel; qualified by valid_out.
- frame_done  out  1  one-cycle pulse after the final pixel's handshake.

## Operation
- Input beat accepted when valid_in && ready_in. Output word transferred when valid_out && ready_out.
- Collection stage: beat counter cnt (0..RATIO-1) and a shift/assembly register.
  - MSB_FIRST=1: beat k goes to bits [OUT_W-1-k*IN_W -: IN_W].
  - MSB_FIRST=0: beat k goes to bits [k*IN_W +: IN_W].
- When beat cnt==RATIO-1 is accepted:
  - The completed word, including that beat, loads the output register. valid_out is set.
  - cnt returns to 0.
- Output register: holds data_out/last_out stable while valid_out && !ready_out. It clears valid_out on handshake unless a new word loads on the same edge; a same-edge load wins and valid_out stays 1.
- ready_in = !reset && !(cnt==RATIO-1 && valid_out && !ready_out). This is combinational from ready_out, so full throughput is one beat per cycle.
- Pixel counter pix (0..FRAME_PIXELS-1):
  - Increments on each output handshake and wraps to 0 after FRAME_PIXELS-1.
  - last_out is 1 when the word in the output register was loaded while pix_at_load == FRAME_PIXELS-1. Track it with a load-side index so stalls do not shift it.
- frame_done: registered, 1 for exactly one cycle after the handshake of a word with last_out=1.
- flush:
  - Sets cnt to 0 and discards the assembly contents. A beat accepted on the same edge is also discarded; flush has priority.
  - The output register and pixel counters are unaffected.
- RATIO=1: each accepted beat loads the output register directly. The pass-through and stall rules are unchanged.
- No overflow or underflow is possible; ready_in backpressure prevents overwrite.

## Timing
- Reset state while reset is high: valid_out=0, data_out=0, last_out=0, frame_done=0, ready_in=0, cnt=0, both pixel indices 0.
- Reset asserted mid-word or mid-frame: the partial word and the pending output are lost, and the frame restarts at pixel 0.
- Latency: final beat accepted at edge N; valid_out=1 and data_out valid from edge N onward, i.e. visible in cycle N+1.
- Stalled output: data_out, last_out and valid_out are constant until the handshake.
- Collection continues for beats 0..RATIO-2 while the output is stalled. Only beat RATIO-1 is held off.
- frame_done rises at the edge after the last-pixel handshake and falls one edge later.

## Test plan
- Basic pack (IN_W=8, RATIO=3, MSB_FIRST=1):
  - Stimulus: beats 0x11, 0x22, 0x33 back-to-back, ready_out=1.
  - Required: data_out=0x112233 and valid_out high for one cycle, one cycle after the third beat; ready_in stays 1.
- Order mode (MSB_FIRST=0): same beats → data_out=0x332211.
- Backpressure:
  - Stimulus: ready_out=0, then stream 6 beats 0x01..0x06.
  - Required: first word 0x010203 held; beats 4–5 accepted; ready_in=0 while beat 6 is pending.
  - Then raise ready_out: 0x010203 transfers, beat 6 is accepted the same cycle, and 0x040506 appears next cycle.
- Frame wrap (FRAME_PIXELS=4):
  - Stimulus: 5 words, with random ready_out stalls.
  - Required: last_out=1 only on word 4; frame_done pulses once, the cycle after word 4's handshake; word 5 has last_out=0 and is pixel 0 of the next frame.
- Flush:
  - Stimulus: send 2 beats, pulse flush together with a third beat, then send 0xAA, 0xBB, 0xCC.
  - Required: the next data_out is 0xAABBCC, and the pixel count is unchanged by the flush.
- Async reset mid-frame:
  - Stimulus: assert reset between clock edges with valid_out=1.
  - Required: valid_out, ready_in and data_out go to 0 immediately; after release, the first packed word is pixel 0 of a new frame.

Source files
------------

// File: rtl/stream_width_packer.sv
// -----------------------------------------------------------------------------
// stream_width_packer
//
// Packs RATIO consecutive IN_W-bit beats from the byte-serial receive stream
// into one OUT_W = IN_W*RATIO bit pixel word. Both sides use valid/ready
// handshakes. Output words are counted per frame; the frame's final word is
// flagged with last_out, and frame_done pulses once after that word leaves.
//
// Parameters:
//   IN_W          input beat width in bits
//   RATIO         input beats per output word
//   MSB_FIRST     1: first beat in top IN_W bits; 0: first beat in bits [IN_W-1:0]
//   FRAME_PIXELS  output words per frame
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   data_in     in   input beat
//   valid_in    in   input beat valid
//   ready_in    out  block can accept a beat (combinational from ready_out)
//   flush       in   synchronous; discards a partially collected word
//   data_out    out  packed word
//   valid_out   out  data_out valid
//   ready_out   in   downstream accepts the word
//   last_out    out  data_out is the frame's final pixel (qualified by valid_out)
//   frame_done  out  one-cycle pulse after the final pixel's handshake
// -----------------------------------------------------------------------------
module stream_width_packer #(
    parameter int IN_W         = 8,
    parameter int RATIO        = 3,
    parameter int MSB_FIRST    = 1,
    parameter int FRAME_PIXELS = 4096,
    localparam int OUT_W       = IN_W * RATIO
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  data_in,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic             flush,
    output logic [OUT_W-1:0] data_out,
    output logic             valid_out,
    input  logic             ready_out,
    output logic             last_out,
    output logic             frame_done
);

    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int PIX_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(FRAME_PIXELS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] asm_q, asm_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             frame_done_q, frame_done_d;
    logic [PIX_W-1:0] pix_q, pix_d;           // handshake-side pixel index
    logic [PIX_W-1:0] load_idx_q, load_idx_d; // load-side pixel index

    logic [OUT_W-1:0] asm_ins;
    logic             in_fire;
    logic             out_fire;

    // Only the word-completing beat must wait for a stalled output register;
    // earlier beats go into the assembly register and never collide with it.
    assign ready_in = !reset && !(cnt_q == CNT_LAST && valid_q && !ready_out);
    assign in_fire  = valid_in && ready_in;
    assign out_fire = valid_q && ready_out;

    // Assembly contents with the current beat dropped into slot cnt_q.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
        asm_ins = asm_q;
        for (int k = 0; k < RATIO; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                if (MSB_FIRST != 0) begin
                    asm_ins[OUT_W-1-k*IN_W -: IN_W] = data_in;
                end else begin
                    asm_ins[k*IN_W +: IN_W] = data_in;
                end
            end
        end
    end

    always_comb begin
        cnt_d        = cnt_q;
        asm_d        = asm_q;
        data_d       = data_q;
        valid_d      = valid_q;
        last_d       = last_q;
        pix_d        = pix_q;
        load_idx_d   = load_idx_q;
        // The word leaving now is pixel pix_q of the frame.
        frame_done_d = out_fire && (pix_q == PIX_LAST);

        if (out_fire) begin
            valid_d = 1'b0;
            pix_d   = (pix_q == PIX_LAST) ? '0 : pix_q + PIX_W'(1);
        end

        // Flush wins over a beat accepted on the same edge.
        if (flush) begin
            cnt_d = '0;
            asm_d = '0;
        end else if (in_fire) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d      = '0;
                asm_d      = '0;
                data_d     = asm_ins;
                valid_d    = 1'b1;  // a same-edge load overrides the handshake clear
                last_d     = (load_idx_q == PIX_LAST);
                load_idx_d = (load_idx_q == PIX_LAST) ? '0 : load_idx_q + PIX_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                asm_d = asm_ins;
            end
        end
    end

    // NOTE: the data path is reset too, so data_out reads 0 during reset rather than stale data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            asm_q        <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            frame_done_q <= 1'b0;
            pix_q        <= '0;
            load_idx_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            cnt_q        <= cnt_d;
            asm_q        <= asm_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            last_q       <= last_d;
            frame_done_q <= frame_done_d;
            pix_q        <= pix_d;
            load_idx_q   <= load_idx_d;
        end
    end

    assign data_out   = data_q;
    assign valid_out  = valid_q;
    assign last_out   = last_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_stream_width_packer.sv
// -----------------------------------------------------------------------------
// tb_stream_width_packer
//
// Two packers (MSB-first and LSB-first) share one input stream. A transaction
// model (queue of collected beats plus one pending output word) predicts the
// outputs; a compare process checks both instances on every falling edge.
// Directed phases pin the model with literal values, then a random phase runs.
// -----------------------------------------------------------------------------
module tb_stream_width_packer;

    localparam int IN_W  = 8;
    localparam int RATIO = 3;
    localparam int OUT_W = IN_W * RATIO;
    localparam int FP    = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [IN_W-1:0]  data_in;
    logic             valid_in;
    logic             flush;
    logic             ready_out;

    logic             ready_in_m, valid_out_m, last_out_m, frame_done_m;
    logic [OUT_W-1:0] data_out_m;
    logic             ready_in_l, valid_out_l, last_out_l, frame_done_l;
    logic [OUT_W-1:0] data_out_l;

    stream_width_packer #(
        .IN_W(IN_W), .RATIO(RATIO), .MSB_FIRST(1), .FRAME_PIXELS(FP)
    ) dut_msb (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_in(ready_in_m), .flush(flush), .data_out(data_out_m),
        .valid_out(valid_out_m), .ready_out(ready_out), .last_out(last_out_m),
        .frame_done(frame_done_m)
    );

    stream_width_packer #(
        .IN_W(IN_W), .RATIO(RATIO), .MSB_FIRST(0), .FRAME_PIXELS(FP)
    ) dut_lsb (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_in(ready_in_l), .flush(flush), .data_out(data_out_l),
        .valid_out(valid_out_l), .ready_out(ready_out), .last_out(last_out_l),
        .frame_done(frame_done_l)
    );

    initial forever #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [IN_W-1:0]  m_beats[$];
    bit               m_valid;
    logic [OUT_W-1:0] m_word_m, m_word_l;
    bit               m_last;
    bit               m_done;
    int               m_loads;

    bit hs_log[$];
    int fd_count;

    task automatic m_clear();
        m_beats.delete();
        m_valid  = 0;
        m_word_m = '0;
        m_word_l = '0;
        m_last   = 0;
        m_done   = 0;
        m_loads  = 0;
    endtask

    function automatic bit m_ready();
        return !reset && !(m_beats.size() == RATIO - 1 && m_valid && !ready_out);
    endfunction

    // One clock edge; inputs are stable across it, so the model evaluates the
    // pre-edge handshakes right after the edge and commits the new state.
    task automatic tick();
        bit fire;
        bit hs;
        fire = valid_in && m_ready();
        hs   = m_valid && ready_out && !reset;
        @(posedge clk);
        if (reset) begin
            m_clear();
        end else begin
            m_done = hs && m_last;
            if (hs) m_valid = 0;
            if (flush) begin
                m_beats.delete();
            end else if (fire) begin
                m_beats.push_back(data_in);
                if (m_beats.size() == RATIO) begin
                    m_word_m = '0;
                    m_word_l = '0;
                    foreach (m_beats[i]) begin
                        m_word_m = (m_word_m << IN_W) | OUT_W'(m_beats[i]);
                        m_word_l = m_word_l | (OUT_W'(m_beats[i]) << (i * IN_W));
                    end
                    m_valid = 1;
                    m_last  = (m_loads % FP) == FP - 1;
                    m_loads++;
                    m_beats.delete();
                end
            end
        end
        #1;
    endtask

    // Offer one beat until the model says it was taken (bounded).
    task automatic send_beat(input logic [IN_W-1:0] d, input bit stall);
        bit taken;
        taken    = 0;
        valid_in = 1'b1;
        data_in  = d;
        for (int i = 0; i < 50 && !taken; i++) begin
            if (stall) ready_out = ($urandom_range(0, 1) == 1);
            taken = m_ready();
            tick();
        end
        if (!taken) check("beat_accept_timeout", 64'(0), 64'(1));
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("ready_in_msb", 64'(ready_in_m), 64'(m_ready()));
        check("ready_in_lsb", 64'(ready_in_l), 64'(m_ready()));
        check("valid_out_msb", 64'(valid_out_m), 64'(m_valid));
        check("valid_out_lsb", 64'(valid_out_l), 64'(m_valid));
        check("frame_done_msb", 64'(frame_done_m), 64'(m_done));
        check("frame_done_lsb", 64'(frame_done_l), 64'(m_done));
        if (m_valid || reset) begin
            check("data_out_msb", 64'(data_out_m), 64'(m_word_m));
            check("data_out_lsb", 64'(data_out_l), 64'(m_word_l));
        end
        if (m_valid) begin
            check("last_out_msb", 64'(last_out_m), 64'(m_last));
            check("last_out_lsb", 64'(last_out_l), 64'(m_last));
        end
        if (valid_out_m && ready_out && !reset) hs_log.push_back(last_out_m);
        if (frame_done_m) fd_count++;
    end

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b1;
        valid_in  = 1'b0;
        flush     = 1'b0;
        ready_out = 1'b1;
        data_in   = '0;
        m_clear();
        fd_count  = 0;
        repeat (3) tick();
        check("reset_ready_in", 64'(ready_in_m), 64'(0));
        check("reset_data_out", 64'(data_out_m), 64'(0));
        #2 reset = 1'b0;

        // Basic pack, both beat orders.
        send_beat(8'h11, 0);
        send_beat(8'h22, 0);
        send_beat(8'h33, 0);
        valid_in = 1'b0;
        check("basic_valid", 64'(valid_out_m), 64'(1));
        check("basic_msb", 64'(data_out_m), 64'h112233);
        check("basic_lsb", 64'(data_out_l), 64'h332211);
        tick();
        check("basic_one_cycle", 64'(valid_out_m), 64'(0));

        // Backpressure: word 1 held, beats 4-5 collected, beat 6 held off.
        ready_out = 1'b0;
        for (int d = 1; d <= 5; d++) send_beat(8'(d), 0);
        valid_in = 1'b1;
        data_in  = 8'h06;
        check("bp_ready_low", 64'(ready_in_m), 64'(0));
        check("bp_valid", 64'(valid_out_m), 64'(1));
        check("bp_hold", 64'(data_out_m), 64'h010203);
        tick();
        tick();
        check("bp_still_held", 64'(data_out_m), 64'h010203);
        check("bp_still_low", 64'(ready_in_m), 64'(0));
        ready_out = 1'b1;
        #1;
        check("bp_ready_release", 64'(ready_in_m), 64'(1));
        tick();
        check("bp_next_word", 64'(data_out_m), 64'h040506);
        check("bp_next_valid", 64'(valid_out_m), 64'(1));
        valid_in = 1'b0;
        tick();

        // Flush with a same-edge beat; this is pixel 3, the frame's last.
        send_beat(8'h5A, 0);
        send_beat(8'h5B, 0);
        data_in = 8'h5C;
        flush   = 1'b1;
        tick();
        flush = 1'b0;
        send_beat(8'hAA, 0);
        send_beat(8'hBB, 0);
        send_beat(8'hCC, 0);
        valid_in = 1'b0;
        check("flush_msb", 64'(data_out_m), 64'hAABBCC);
        check("flush_lsb", 64'(data_out_l), 64'hCCBBAA);
        check("flush_pix_last", 64'(last_out_m), 64'(1));
        tick();
        check("flush_frame_done", 64'(frame_done_m), 64'(1));
        tick();
        check("frame_done_pulse_end", 64'(frame_done_m), 64'(0));

        // Asynchronous reset between edges while a word is pending.
        ready_out = 1'b0;
        send_beat(8'h77, 0);
        send_beat(8'h88, 0);
        send_beat(8'h99, 0);
        valid_in = 1'b0;
        check("pre_reset_valid", 64'(valid_out_m), 64'(1));
        #2 reset = 1'b1;
        m_clear();
        #1;
        check("async_valid", 64'(valid_out_m), 64'(0));
        check("async_ready", 64'(ready_in_m), 64'(0));
        check("async_data", 64'(data_out_m), 64'(0));
        tick();
        tick();
        #2 reset = 1'b0;
        ready_out = 1'b1;

        // Frame wrap: five words with random output stalls.
        hs_log.delete();
        fd_count = 0;
        for (int w = 0; w < 5; w++)
            for (int b = 0; b < RATIO; b++) send_beat(8'($urandom), 1);
        valid_in  = 1'b0;
        ready_out = 1'b1;
        repeat (4) tick();
        check("wrap_words", 64'(hs_log.size()), 64'(5));
        if (hs_log.size() == 5)
            foreach (hs_log[i]) check("wrap_last", 64'(hs_log[i]), 64'(i == 3));
        check("wrap_frame_done_count", 64'(fd_count), 64'(1));

        // Random traffic with stalls and occasional flushes.
        repeat (400) begin
            valid_in  = ($urandom_range(0, 3) != 0);
            data_in   = 8'($urandom);
            ready_out = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            tick();
        end
        flush     = 1'b0;
        valid_in  = 1'b0;
        ready_out = 1'b1;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
